turf_wb_arbiter: RTL
====================

# turf_wb_arbiter

Round-robin WISHBONE bus arbiter and bus watchdog for the TURF global interconnect. It owns the shared master-side bus and grants it to one of NUM_MASTERS requesters for the whole duration of that requester's cycle (cyc). It terminates stalled transfers with an injected error, because unmapped or hung slaves never ack. It replaces the single-master priority arbiter in the interconnect once the crate bridge and local masters share the bus.

## Interface
- NUM_MASTERS, 4: number of requesting masters, 1..16.
- TIMEOUT, 256: cycles a strobe may stay unterminated before a forced error, 2..65535.

- clk_i  in  1  bus clock; all logic in this domain.
- rst_i  in  1  asynchronous, active-high reset.
- cyc_i  in  NUM_MASTERS  per-master cyc requests.
- stb_i  in  1  strobe of the currently granted master (muxed by the interconnect).
- ack_i  in  1  muxed slave ack.
- err_i  in  1  muxed slave err.
- rty_i  in  1  muxed slave rty.
- gnt_o  out  NUM_MASTERS  one-hot grant, registered; all-zero when idle.
- tmo_err_o  out  1  one-cycle error pulse to the granted master's err.
- abort_o  out  1  one-cycle force-low of slave cyc/stb, coincident with tmo_err_o.
- tmo_count_o  out  16  saturating count of watchdog timeouts.
- tmo_master_o  out  4  index of the master granted at the most recent timeout.

## Operation
- Reset: gnt_o=0, tmo_err_o=0, abort_o=0, tmo_count_o=0, tmo_master_o=0. Round-robin pointer = NUM_MASTERS-1, so master 0 wins first. Watchdog counter = 0. State = IDLE.
- termination = ack_i | err_i | rty_i.
- States:
  - IDLE: if any cyc_i bit is set, the winner is the first set bit searching upward from pointer+1 (modulo NUM_MASTERS). Register gnt_o=onehot(winner), set pointer=winner, go to OWNED.
  - OWNED: the grant holds while cyc_i[pointer]=1, regardless of other requests (no preemption).
    - When cyc_i[pointer] drops: if any other cyc_i bit is set, grant the next winner directly (stay in OWNED, pointer updates). Otherwise gnt_o goes to 0 and the state goes to IDLE.
    - Watchdog: the counter increments on each cycle with stb_i=1 and termination=0. It clears on termination or stb_i=0. When the counter is at TIMEOUT-1 and that cycle has no termination, go to TMO.
  - TMO: exactly one cycle. tmo_err_o=1, abort_o=1, counter cleared, tmo_count_o incremented (saturates at 16'hFFFF), tmo_master_o=pointer. Return to OWNED; the grant is unchanged.
- The grant change and watchdog clear happen together. A new grant starts with counter=0.
- NUM_MASTERS=1: the search degenerates; master 0 is always the winner when it requests.
- A cyc_i drop during TMO is honoured on the return to OWNED: the next cycle sees cyc_i low and releases.

## Timing
- Grant latency: cyc_i rising in cycle n (bus idle) gives gnt_o set in cycle n+1.
- Handover: cyc_i[owner] low in cycle n gives the new gnt_o in cycle n+1. There is no idle cycle when another master is waiting.
- Release: gnt_o stays high for the one cycle after the owner drops cyc. Slaves are safe because the interconnect ANDs cyc with the master's cyc.
- Watchdog:
  - If stb_i is high and unterminated in cycles 1..TIMEOUT, tmo_err_o and abort_o are high in cycle TIMEOUT+1 only.
  - A termination in cycle TIMEOUT (the boundary) wins: no timeout, counter cleared.
  - An ack_i arriving in the TMO cycle is ignored. The interconnect gates slave ack/rty with ~abort_o, and err_o = muxed err | tmo_err_o.
- Back-to-back stalled strobes: after TMO, a still-high stb_i restarts counting at 0. The next timeout follows TIMEOUT+1 cycles later.
- rst_i assertion mid-transfer clears all outputs asynchronously, including an in-flight tmo pulse. The first grant after release follows the IDLE rules.

## Test plan
- Reset, then cyc_i=4'b0110 from cycle 0:
  - gnt_o=4'b0010 in cycle 1.
  - Drop cyc_i[1] in cycle 5 → gnt_o=4'b0100 in cycle 6.
- Fairness, NUM_MASTERS=4: all cyc_i held high, each owner drops cyc after 3 cycles. Required grant order 0,1,2,3,0 with no idle cycles between grants.
- No preemption: master 2 owns the bus; master 0 raises cyc_i. gnt_o stays 4'b0100 until cyc_i[2] falls.
- Timeout, TIMEOUT=8: stb_i high, no ack, from cycle 1.
  - tmo_err_o=abort_o=1 in cycle 9 only.
  - tmo_count_o=1, tmo_master_o=owner index.
  - With stb still high, the second pulse is in cycle 18.
- Boundary, TIMEOUT=8: ack_i in cycle 8 → no tmo_err_o, tmo_count_o stays 0.
- Async reset: assert rst_i mid-transfer and mid-count → gnt_o=0 with no clock edge. After release, cyc_i=4'b1000 → gnt_o=4'b1000 one cycle later, counter restarts at 0.

Source files
------------

// File: rtl/turf_wb_arbiter.sv
// Round-robin WISHBONE arbiter for the TURF global interconnect with a bus watchdog
// that terminates stalled strobes by injecting an error and aborting the slave cycle.
module turf_wb_arbiter #(
    parameter int NUM_MASTERS = 4,
    parameter int TIMEOUT     = 256
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [NUM_MASTERS-1:0] cyc_i,
    input  logic                   stb_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   rty_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   tmo_err_o,
    output logic                   abort_o,
    output logic [15:0]            tmo_count_o,
    output logic [3:0]             tmo_master_o
);

    localparam int          IW       = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam logic [15:0] WD_LAST  = 16'(TIMEOUT - 1);
    localparam logic [3:0]  PTR_INIT = 4'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWNED = 2'd1,
        ST_TMO   = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic [3:0]              ptr_reg, ptr_next;
    logic [15:0]             wd_cnt_reg, wd_cnt_next;
    logic [NUM_MASTERS-1:0]  gnt_reg, gnt_next;
    logic                    tmo_err_reg, tmo_err_next;
    logic                    abort_reg, abort_next;
    logic [15:0]             tmo_count_reg, tmo_count_next;
    logic [3:0]              tmo_master_reg, tmo_master_next;

    logic [3:0]              cand_idx [NUM_MASTERS];
    logic [NUM_MASTERS-1:0]  rot_req;
    logic [3:0]              win_idx;
    logic [NUM_MASTERS-1:0]  win_onehot;
    logic                    any_req;
    logic                    owner_cyc;
    logic                    term;

    assign term      = ack_i | err_i | rty_i;
    assign owner_cyc = cyc_i[ptr_reg[IW-1:0]];

    // Candidate gi is the master gi+1 places above the pointer, wrapping modulo NUM_MASTERS.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_cand
            logic [4:0] sum;
            assign sum          = {1'b0, ptr_reg} + 5'(gi + 1);
            assign cand_idx[gi] = (sum >= 5'(NUM_MASTERS)) ? 4'(sum - 5'(NUM_MASTERS)) : sum[3:0];
            assign rot_req[gi]  = cyc_i[cand_idx[gi][IW-1:0]];
        end
    endgenerate

    always_comb begin
        any_req = |rot_req;
        win_idx = ptr_reg;
        for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
            if (rot_req[i]) win_idx = cand_idx[i];
        end
        win_onehot = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            win_onehot[i] = (win_idx == 4'(i));
        end
    end

    always_comb begin
        state_next      = state_reg;
        ptr_next        = ptr_reg;
        wd_cnt_next     = wd_cnt_reg;
        gnt_next        = gnt_reg;
        tmo_err_next    = 1'b0;
        abort_next      = 1'b0;
        tmo_count_next  = tmo_count_reg;
        tmo_master_next = tmo_master_reg;

        case (state_reg)
            ST_IDLE: begin
                wd_cnt_next = '0;
                if (any_req) begin
                    gnt_next   = win_onehot;
                    ptr_next   = win_idx;
                    state_next = ST_OWNED;
                end
            end
            ST_OWNED: begin
                if (!owner_cyc) begin
                    // Release or direct handover; a handover always starts a fresh watchdog.
                    wd_cnt_next = '0;
                    if (any_req) begin
                        gnt_next = win_onehot;
                        ptr_next = win_idx;
                    end else begin
                        gnt_next   = '0;
                        state_next = ST_IDLE;
                    end
                end else if (stb_i && !term) begin
                    if (wd_cnt_reg == WD_LAST) begin
                        wd_cnt_next     = '0;
                        tmo_err_next    = 1'b1;
                        abort_next      = 1'b1;
                        tmo_master_next = ptr_reg;
                        if (tmo_count_reg != 16'hFFFF) tmo_count_next = tmo_count_reg + 16'd1;
                        state_next      = ST_TMO;
                    end else begin
                        wd_cnt_next = wd_cnt_reg + 16'd1;
                    end
                end else begin
                    wd_cnt_next = '0;
                end
            end
            ST_TMO: begin
                // The abort cycle is not counted and ignores any late termination.
                wd_cnt_next = '0;
                state_next  = ST_OWNED;
            end
            default: begin
                state_next  = ST_IDLE;
                gnt_next    = '0;
                wd_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= PTR_INIT;
            wd_cnt_reg     <= '0;
            gnt_reg        <= '0;
            tmo_err_reg    <= 1'b0;
            abort_reg      <= 1'b0;
            tmo_count_reg  <= '0;
            tmo_master_reg <= '0;
        end else begin
            state_reg      <= state_next;
            ptr_reg        <= ptr_next;
            wd_cnt_reg     <= wd_cnt_next;
            gnt_reg        <= gnt_next;
            tmo_err_reg    <= tmo_err_next;
            abort_reg      <= abort_next;
            tmo_count_reg  <= tmo_count_next;
            tmo_master_reg <= tmo_master_next;
        end
    end

    assign gnt_o        = gnt_reg;
    assign tmo_err_o    = tmo_err_reg;
    assign abort_o      = abort_reg;
    assign tmo_count_o  = tmo_count_reg;
    assign tmo_master_o = tmo_master_reg;

endmodule
